serial_word_rx: RTL

Serial-to-parallel receiver that reassembles words shifted out one bit per cycle by the team's universal shift register operating in shift-left or shift-right mode. It sits at the far end of the serial link and accepts bits qualified by `sin_valid`. It rebuilds each `WIDTH`-bit word in MSB-first or LSB-first order and presents it on a valid/ready output port. It flags overruns and, optionally, parity errors.

---
 rtl/univshift_pkg.sv | 6 +
 rtl/swrx_shift_core.sv | 44 ++++
 rtl/serial_word_rx.sv | 87 ++++++++
 3 files changed

// File: rtl/univshift_pkg.sv
// univshift_pkg: shared FSM states and shift-direction constants for the serial link
package univshift_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PAR} state_t;
    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;
endpackage

// File: rtl/swrx_shift_core.sv
// swrx_shift_core: shift register, bit counter and frame-done pulse for serial_word_rx
module swrx_shift_core
    import univshift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1),
    parameter bit HOLD  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             first,
    input  logic             msb_first,
    input  logic             sin,
    output logic [WIDTH-1:0] word,
    output logic             done
);
    logic [WIDTH-1:0] sh, sh_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic dir, use_dir;
    // next shift value; the first bit of a frame uses the live direction input
    always_comb begin
        use_dir = first ? msb_first : dir;
        sh_nxt  = (use_dir == DIR_MSB) ? {sh[WIDTH-2:0], sin} : {sin, sh[WIDTH-1:1]};
        cnt_nxt = first ? CNT_W'(1) : cnt + CNT_W'(1);
        done    = en && (cnt_nxt == CNT_W'(WIDTH));
        word    = HOLD ? sh : sh_nxt;
    end
    // shift register, bit counter and latched frame direction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh  <= '0;
            cnt <= '0;
            dir <= DIR_LSB;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            sh  <= sh_nxt;
            cnt <= done ? '0 : cnt_nxt;
            if (first) dir <= msb_first;
        end
    end
endmodule

// File: rtl/serial_word_rx.sv
// serial_word_rx: serial-to-parallel word receiver with valid/ready output; SWRX_PARITY_EN adds even parity
module serial_word_rx
    import univshift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             msb_first,
    input  logic             clear,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun
`ifdef SWRX_PARITY_EN
    ,
    output logic             parity_err
`endif
);
`ifdef SWRX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    state_t state, state_nxt;
    logic en, first, done, complete;
    logic [WIDTH-1:0] word;
`ifdef SWRX_PARITY_EN
    logic pe;
    assign pe = ^{word, sin};
`endif
    swrx_shift_core #(.WIDTH(WIDTH), .CNT_W(CNT_W), .HOLD(PAR_EN)) u_core (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .en(en),
        .first(first),
        .msb_first(msb_first),
        .sin(sin),
        .word(word),
        .done(done)
    );
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else state <= state_nxt;
    end
    // next state: clear wins, gaps hold, last data bit ends the frame or enters PAR
    always_comb begin
        state_nxt = clear ? ST_IDLE :
                    !sin_valid ? state :
                    (state == ST_IDLE) ? ST_SHIFT :
                    (state == ST_PAR) ? ST_IDLE :
                    done ? (PAR_EN ? ST_PAR : ST_IDLE) : ST_SHIFT;
    end
    // FSM outputs: shift enable, frame start and word completion
    always_comb begin
        first    = (state == ST_IDLE);
        en       = sin_valid && !clear && (state != ST_PAR);
        complete = PAR_EN ? (state == ST_PAR && sin_valid && !clear) : done;
    end
    // output slot and sticky overrun; a handshake frees the slot for a same-cycle word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef SWRX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (complete && (!dout_valid || dout_ready)) begin
                dout       <= word;
                dout_valid <= 1'b1;
`ifdef SWRX_PARITY_EN
                parity_err <= pe;
`endif
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
            overrun <= clear ? 1'b0 : (complete && dout_valid && !dout_ready) ? 1'b1 : overrun;
        end
    end
endmodule
